// File: rtl/tiny45_serial_alu_if.sv
// ---------------------------------------------------------------------------
// tiny45_serial_alu_if
// Request/response bundle for the tiny45 digit-serial ALU.
//   in_valid / in_ready   : request handshake (op, a, b qualify in_valid)
//   op                    : {ext, RISC-V ALU op[3:0]}
//   a, b                  : operands (shifts use b[clog2(DATA_W)-1:0])
//   out_valid / out_ready : result handshake (d, cmp qualify out_valid)
// Modports: master = requester/consumer, slave = the ALU engine.
// ---------------------------------------------------------------------------
interface tiny45_serial_alu_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] d;
    logic              cmp;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, d, cmp
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, d, cmp
    );
endinterface

// File: rtl/tiny45_serial_alu.sv
// ---------------------------------------------------------------------------
// tiny45_serial_alu
// Digit-serial ALU/shifter: accepts two DATA_W operands and an opcode, then
// processes one DIGIT_W-bit digit per clock, LSB digit first, keeping carry
// and equality state between digits. Result and compare flag are returned
// over a valid/ready handshake.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (aborts any operation in flight)
//   bus  : tiny45_serial_alu_if.slave (request/response handshake)
//
// Parameters:
//   DATA_W  : operand/result width, multiple of DIGIT_W
//   DIGIT_W : bits per cycle, power of two
//
// Optional feature macro: TINY45_SERIAL_ALU_MINMAX_EN
//   defined   -> op[4]=1 codes MIN/MINU/MAX/MAXU, one extra SEL cycle
//   undefined -> every op[4]=1 code returns d=0, cmp=0
// ---------------------------------------------------------------------------
module tiny45_serial_alu #(
    parameter int DATA_W  = 32,
    parameter int DIGIT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    tiny45_serial_alu_if.slave bus
);
    localparam int NDIG  = DATA_W / DIGIT_W;
    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    typedef enum logic [3:0] {
        K_ADD, K_SUB, K_SLT, K_SLTU, K_AND, K_OR, K_XOR,
        K_SLL, K_SRL, K_SRA, K_MIN, K_MINU, K_MAX, K_MAXU, K_BAD
    } kind_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
`ifdef TINY45_SERIAL_ALU_MINMAX_EN
        S_SEL  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_e;

    // Opcode to operation kind; unknown encodings collapse to K_BAD (d=0, cmp=0).
    function automatic kind_e decode_op(input logic [4:0] op);
        kind_e k;
        k = K_BAD;
        if (op[4] == 1'b0) begin
            case (op[3:0])
                4'b0000: k = K_ADD;
                4'b1000: k = K_SUB;
                4'b0010: k = K_SLT;
                4'b0011: k = K_SLTU;
                4'b0111: k = K_AND;
                4'b0110: k = K_OR;
                4'b0100: k = K_XOR;
                4'b0001: k = K_SLL;
                4'b0101: k = K_SRL;
                4'b1101: k = K_SRA;
                default: k = K_BAD;
            endcase
        end else begin
`ifdef TINY45_SERIAL_ALU_MINMAX_EN
            case (op[3:0])
                4'b0010: k = K_MIN;
                4'b0011: k = K_MINU;
                4'b0110: k = K_MAX;
                4'b0111: k = K_MAXU;
                default: k = K_BAD;
            endcase
`else
            k = K_BAD;
`endif
        end
        return k;
    endfunction

    state_e                          state_r;
    kind_e                           kind_r;
    logic [DATA_W-1:0]               a_r;
    logic [DATA_W-1:0]               b_r;
    logic [CNT_W-1:0]                cnt_r;
    logic                            carry_r;
    logic                            eq_r;
    logic                            cmp_r;
    logic [NDIG-1:0][DIGIT_W-1:0]    res_r;

    logic [NDIG-1:0][DIGIT_W-1:0]    a_digs_s;
    logic [NDIG-1:0][DIGIT_W-1:0]    b_digs_s;
    logic [NDIG-1:0][DIGIT_W-1:0]    sll_s;
    logic [NDIG-1:0][DIGIT_W-1:0]    srl_s;
    logic [NDIG-1:0][DIGIT_W-1:0]    sra_s;
    logic [DIGIT_W-1:0]              a_dig_s;
    logic [DIGIT_W-1:0]              b_dig_s;
    logic [DIGIT_W-1:0]              b_eff_s;
    logic [DIGIT_W:0]                add_s;
    logic                            inv_b_s;
    logic                            signed_cmp_s;
    logic                            is_max_s;
    logic                            eq_next_s;
    logic                            lt_s;
    logic [DIGIT_W-1:0]              dig_s;

    // Operation attributes derived from the latched kind.
    always_comb begin
        inv_b_s      = 1'b0;
        signed_cmp_s = 1'b0;
        is_max_s     = 1'b0;
        case (kind_r)
            K_SUB:   inv_b_s = 1'b1;
            K_SLT:   begin inv_b_s = 1'b1; signed_cmp_s = 1'b1; end
            K_SLTU:  inv_b_s = 1'b1;
            K_MIN:   begin inv_b_s = 1'b1; signed_cmp_s = 1'b1; end
            K_MINU:  inv_b_s = 1'b1;
            K_MAX:   begin inv_b_s = 1'b1; signed_cmp_s = 1'b1; is_max_s = 1'b1; end
            K_MAXU:  begin inv_b_s = 1'b1; is_max_s = 1'b1; end
            default: inv_b_s = 1'b0;
        endcase
    end

    // Current-digit datapath: digit adder, equality, shifter views, compare.
    always_comb begin
        a_digs_s  = a_r;
        b_digs_s  = b_r;
        // Shifts read the whole latched A so bits can cross digit boundaries.
        sll_s     = a_r << b_r[SH_W-1:0];
        srl_s     = a_r >> b_r[SH_W-1:0];
        sra_s     = $signed(a_r) >>> b_r[SH_W-1:0];
        a_dig_s   = a_digs_s[cnt_r];
        b_dig_s   = b_digs_s[cnt_r];
        b_eff_s   = inv_b_s ? ~b_dig_s : b_dig_s;
        add_s     = {1'b0, a_dig_s} + {1'b0, b_eff_s} + {{DIGIT_W{1'b0}}, carry_r};
        eq_next_s = eq_r & (a_dig_s == b_dig_s);
        // Only meaningful on the last digit, where add_s carries the final carry-out.
        if (signed_cmp_s) begin
            lt_s = a_r[DATA_W-1] ^ ~b_r[DATA_W-1] ^ add_s[DIGIT_W];
        end else begin
            lt_s = ~add_s[DIGIT_W];
        end
    end

    // Result digit for the current position.
    always_comb begin
        dig_s = {DIGIT_W{1'b0}};
        case (kind_r)
            K_ADD:   dig_s = add_s[DIGIT_W-1:0];
            K_SUB:   dig_s = add_s[DIGIT_W-1:0];
            K_AND:   dig_s = a_dig_s & b_dig_s;
            K_OR:    dig_s = a_dig_s | b_dig_s;
            K_XOR:   dig_s = a_dig_s ^ b_dig_s;
            K_SLL:   dig_s = sll_s[cnt_r];
            K_SRL:   dig_s = srl_s[cnt_r];
            K_SRA:   dig_s = sra_s[cnt_r];
            default: dig_s = {DIGIT_W{1'b0}};
        endcase
    end

    // Sequencing FSM with registered result, flag and per-digit state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            kind_r  <= K_BAD;
            a_r     <= '0;
            b_r     <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            eq_r    <= 1'b0;
            cmp_r   <= 1'b0;
            res_r   <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        kind_r  <= decode_op(bus.op);
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        cnt_r   <= '0;
                        carry_r <= bus.op[3] | bus.op[1];
                        eq_r    <= 1'b1;
                        cmp_r   <= 1'b0;
                        state_r <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_r[cnt_r] <= dig_s;
                    carry_r      <= add_s[DIGIT_W];
                    eq_r         <= eq_next_s;
                    cnt_r        <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_DIG) begin
                        cnt_r   <= '0;
                        state_r <= S_DONE;
                        case (kind_r)
                            K_SLT, K_SLTU: begin
                                cmp_r <= lt_s;
                                res_r <= {{(DATA_W-1){1'b0}}, lt_s};
                            end
                            K_XOR: cmp_r <= eq_next_s;
`ifdef TINY45_SERIAL_ALU_MINMAX_EN
                            K_MIN, K_MINU, K_MAX, K_MAXU: begin
                                cmp_r   <= lt_s;
                                state_r <= S_SEL;
                            end
`endif
                            default: cmp_r <= 1'b0;
                        endcase
                    end
                end
`ifdef TINY45_SERIAL_ALU_MINMAX_EN
                S_SEL: begin
                    // MIN keeps A when A<B; MAX keeps A when A>=B.
                    res_r   <= (cmp_r ^ is_max_s) ? a_r : b_r;
                    state_r <= S_DONE;
                end
`endif
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_r <= S_IDLE;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    // in_ready is suppressed while rst is high even though state is already IDLE.
    assign bus.in_ready  = (state_r == S_IDLE) & ~rst;
    assign bus.out_valid = (state_r == S_DONE);
    assign bus.d         = res_r;
    assign bus.cmp       = cmp_r;

endmodule

// File: tb/tb_tiny45_serial_alu.sv
// ---------------------------------------------------------------------------
// tb_tiny45_serial_alu
// Directed self-checking bench: a 32/4 instance for the main operations,
// backpressure and mid-operation reset, and a 16/8 instance for the narrow
// configuration and the op[4] extension codes.
// ---------------------------------------------------------------------------
module tb_tiny45_serial_alu;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        c;
        logic [7:0]  lat;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    tiny45_serial_alu_if #(.DATA_W(32)) bus32 ();
    tiny45_serial_alu_if #(.DATA_W(16)) bus16 ();

    tiny45_serial_alu #(.DATA_W(32), .DIGIT_W(4)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    tiny45_serial_alu #(.DATA_W(16), .DIGIT_W(8)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request on the 32-bit instance (called #1 after an edge, idle DUT).
    task automatic run32(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output logic c, output int lat);
        bus32.op        = o;
        bus32.a         = x;
        bus32.b         = y;
        bus32.in_valid  = 1'b1;
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        lat = 0;
        while (bus32.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus32.d;
        c   = bus32.cmp;
        @(posedge clk); #1;
    endtask

    task automatic run16(input logic [4:0] o, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] res, output logic c, output int lat);
        bus16.op        = o;
        bus16.a         = x;
        bus16.b         = y;
        bus16.in_valid  = 1'b1;
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        lat = 0;
        while (bus16.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus16.d;
        c   = bus16.cmp;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus32.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got %b want 0", bus32.in_ready); end
        total++; if (bus32.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", bus32.out_valid); end
        total++; if (bus32.d !== 32'h0) begin bad++; $display("FAIL reset_d got %h want 0", bus32.d); end
        total++; if (bus32.cmp !== 1'b0) begin bad++; $display("FAIL reset_cmp got %b want 0", bus32.cmp); end
        total++; if (bus16.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready16 got %b want 0", bus16.in_ready); end
        rst = 1'b0;
        #1;
        total++; if (bus32.in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got %b want 1", bus32.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        logic [31:0] r;
        logic        c;
        int          lat;
        run32(5'b00000, 32'hFFFFFFFF, 32'h00000001, r, c, lat);
        total++; if (r !== 32'h00000000) begin bad++; $display("FAIL add_d got %h want 00000000", r); end
        total++; if (c !== 1'b0) begin bad++; $display("FAIL add_cmp got %b want 0", c); end
        total++; if (lat !== 8) begin bad++; $display("FAIL add_latency got %0d want 8", lat); end
        total++; if (bus32.in_ready !== 1'b1) begin bad++; $display("FAIL add_in_ready_after got %b want 1", bus32.in_ready); end
    endtask

    task automatic test_arith();
        vec_t        tv [14];
        logic [31:0] r;
        logic        c;
        int          lat;
        tv[0]  = '{5'b01000, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 8'd8};
        tv[1]  = '{5'b00010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 8'd8};
        tv[2]  = '{5'b00011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 8'd8};
        tv[3]  = '{5'b00100, 32'h1234ABCD, 32'h1234ABCD, 32'h00000000, 1'b1, 8'd8};
        tv[4]  = '{5'b00100, 32'h1234ABCD, 32'h1234ABCC, 32'h00000001, 1'b0, 8'd8};
        tv[5]  = '{5'b00010, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 8'd8};
        tv[6]  = '{5'b00011, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b1, 8'd8};
        tv[7]  = '{5'b00111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 8'd8};
        tv[8]  = '{5'b00110, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 8'd8};
        tv[9]  = '{5'b01010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 8'd8};
        tv[10] = '{5'b00010, 32'h00000007, 32'h00000007, 32'h00000000, 1'b0, 8'd8};
        tv[11] = '{5'b00000, 32'h12345678, 32'h0FEDCBA8, 32'h22222220, 1'b0, 8'd8};
        tv[12] = '{5'b00100, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0, 8'd8};
        tv[13] = '{5'b00010, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 8'd8};
        for (int i = 0; i < 14; i++) begin
            run32(tv[i].op, tv[i].a, tv[i].b, r, c, lat);
            total++; if (r !== tv[i].d) begin bad++; $display("FAIL arith_d[%0d] got %h want %h", i, r, tv[i].d); end
            total++; if (c !== tv[i].c) begin bad++; $display("FAIL arith_cmp[%0d] got %b want %b", i, c, tv[i].c); end
            total++; if (lat !== int'(tv[i].lat)) begin bad++; $display("FAIL arith_lat[%0d] got %0d want %0d", i, lat, tv[i].lat); end
        end
    endtask

    task automatic test_shift();
        vec_t        tv [9];
        logic [31:0] r;
        logic        c;
        int          lat;
        tv[0] = '{5'b01101, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 8'd8};
        tv[1] = '{5'b00001, 32'h00000001, 32'd31,       32'h80000000, 1'b0, 8'd8};
        tv[2] = '{5'b00101, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1'b0, 8'd8};
        tv[3] = '{5'b00101, 32'hF0000000, 32'd4,        32'h0F000000, 1'b0, 8'd8};
        tv[4] = '{5'b01101, 32'h40000000, 32'd4,        32'h04000000, 1'b0, 8'd8};
        tv[5] = '{5'b00001, 32'h00000001, 32'hFFFFFFE4, 32'h00000010, 1'b0, 8'd8};
        tv[6] = '{5'b01101, 32'hDEADBEEF, 32'd8,        32'hFFDEADBE, 1'b0, 8'd8};
        tv[7] = '{5'b00101, 32'hDEADBEEF, 32'd13,       32'h0006F56D, 1'b0, 8'd8};
        tv[8] = '{5'b00001, 32'hDEADBEEF, 32'd4,        32'hEADBEEF0, 1'b0, 8'd8};
        for (int i = 0; i < 9; i++) begin
            run32(tv[i].op, tv[i].a, tv[i].b, r, c, lat);
            total++; if (r !== tv[i].d) begin bad++; $display("FAIL shift_d[%0d] got %h want %h", i, r, tv[i].d); end
            total++; if (c !== tv[i].c) begin bad++; $display("FAIL shift_cmp[%0d] got %b want %b", i, c, tv[i].c); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bus32.op        = 5'b00000;
        bus32.a         = 32'd2;
        bus32.b         = 32'd3;
        bus32.in_valid  = 1'b1;
        bus32.out_ready = 1'b0;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        lat = 0;
        while (bus32.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        total++; if (lat !== 8) begin bad++; $display("FAIL bp_latency got %0d want 8", lat); end
        // New request presented while the result is still pending.
        bus32.op       = 5'b01000;
        bus32.a        = 32'd9;
        bus32.b        = 32'd4;
        bus32.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++; if (bus32.out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid[%0d] got %b want 1", i, bus32.out_valid); end
            total++; if (bus32.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, bus32.in_ready); end
            total++; if (bus32.d !== 32'd5) begin bad++; $display("FAIL bp_d_hold[%0d] got %h want 00000005", i, bus32.d); end
            total++; if (bus32.cmp !== 1'b0) begin bad++; $display("FAIL bp_cmp_hold[%0d] got %b want 0", i, bus32.cmp); end
            @(posedge clk); #1;
        end
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (bus32.in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle_after_hs got %b want 1", bus32.in_ready); end
        total++; if (bus32.out_valid !== 1'b0) begin bad++; $display("FAIL bp_out_valid_after_hs got %b want 0", bus32.out_valid); end
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        total++; if (bus32.in_ready !== 1'b0) begin bad++; $display("FAIL bp_accept_new got %b want 0", bus32.in_ready); end
        lat = 0;
        while (bus32.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        total++; if (lat !== 8) begin bad++; $display("FAIL bp_new_latency got %0d want 8", lat); end
        total++; if (bus32.d !== 32'd5) begin bad++; $display("FAIL bp_new_d got %h want 00000005", bus32.d); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        logic        c;
        int          lat;
        logic        seen;
        bus32.op        = 5'b00000;
        bus32.a         = 32'h11111111;
        bus32.b         = 32'h22222222;
        bus32.in_valid  = 1'b1;
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++; if (bus32.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got %b want 0", bus32.out_valid); end
        total++; if (bus32.d !== 32'h0) begin bad++; $display("FAIL midrst_d got %h want 00000000", bus32.d); end
        total++; if (bus32.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got %b want 1", bus32.in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus32.out_valid === 1'b1) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_result got %b want 0", seen); end
        run32(5'b00000, 32'd2, 32'd3, r, c, lat);
        total++; if (r !== 32'd5) begin bad++; $display("FAIL midrst_add_d got %h want 00000005", r); end
        total++; if (lat !== 8) begin bad++; $display("FAIL midrst_add_lat got %0d want 8", lat); end
    endtask

    task automatic test_narrow();
        vec_t        tv [7];
        logic [15:0] r;
        logic        c;
        int          lat;
        tv[0] = '{5'b00000, 32'h00FF, 32'h0001, 32'h0100, 1'b0, 8'd2};
        tv[1] = '{5'b01000, 32'h0001, 32'h0002, 32'hFFFF, 1'b0, 8'd2};
        tv[2] = '{5'b00010, 32'h8000, 32'h0001, 32'h0001, 1'b1, 8'd2};
`ifdef TINY45_SERIAL_ALU_MINMAX_EN
        tv[3] = '{5'b10011, 32'h8000, 32'h0001, 32'h0001, 1'b0, 8'd3};
        tv[4] = '{5'b10010, 32'h8000, 32'h0001, 32'h8000, 1'b1, 8'd3};
        tv[5] = '{5'b10110, 32'h8000, 32'h0001, 32'h0001, 1'b1, 8'd3};
        tv[6] = '{5'b10111, 32'h8000, 32'h0001, 32'h8000, 1'b0, 8'd3};
`else
        tv[3] = '{5'b10011, 32'h8000, 32'h0001, 32'h0000, 1'b0, 8'd2};
        tv[4] = '{5'b10010, 32'h8000, 32'h0001, 32'h0000, 1'b0, 8'd2};
        tv[5] = '{5'b10110, 32'h8000, 32'h0001, 32'h0000, 1'b0, 8'd2};
        tv[6] = '{5'b10111, 32'h8000, 32'h0001, 32'h0000, 1'b0, 8'd2};
`endif
        for (int i = 0; i < 7; i++) begin
            run16(tv[i].op, tv[i].a[15:0], tv[i].b[15:0], r, c, lat);
            total++; if (r !== tv[i].d[15:0]) begin bad++; $display("FAIL narrow_d[%0d] got %h want %h", i, r, tv[i].d[15:0]); end
            total++; if (c !== tv[i].c) begin bad++; $display("FAIL narrow_cmp[%0d] got %b want %b", i, c, tv[i].c); end
            total++; if (lat !== int'(tv[i].lat)) begin bad++; $display("FAIL narrow_lat[%0d] got %0d want %0d", i, lat, tv[i].lat); end
        end
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        rst             = 1'b1;
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b0;
        bus32.op        = 5'b00000;
        bus32.a         = 32'h0;
        bus32.b         = 32'h0;
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b0;
        bus16.op        = 5'b00000;
        bus16.a         = 16'h0;
        bus16.b         = 16'h0;
        test_reset();
        test_add();
        test_arith();
        test_shift();
        test_backpressure();
        test_reset_mid();
        test_narrow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
